// File: rtl/idex_pkg.sv
// Shared constants and types for the ID/EX stage register.
// idex_bundle_t describes the stage payload at the default widths.
package idex_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int REG_W_DEF  = 5;
  localparam int ALU_W_DEF  = 3;

  localparam logic [ALU_W_DEF-1:0] ALU_NOP  = '0;
  localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ALU_W_DEF-1:0]  alu_sig;
    logic                  wb;
    logic [DATA_W_DEF-1:0] r1;
    logic [DATA_W_DEF-1:0] r2;
    logic [REG_W_DEF-1:0]  rd;
    logic [REG_W_DEF-1:0]  rs;
    logic [REG_W_DEF-1:0]  rt;
  } idex_bundle_t;

endpackage

// File: rtl/idex_stage_reg_if.sv
// Decode-to-execute bundle plus hazard/branch control for idex_stage_reg.
// Counter outputs exist only when IDEX_PERF_CNT_EN is defined.
interface idex_stage_reg_if
  import idex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int ALU_W  = ALU_W_DEF
`ifdef IDEX_PERF_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
);

  logic              stall;
  logic              flush;
  logic              valid_in;
  logic [ALU_W-1:0]  alu_sig_in;
  logic              wb_in;
  logic [DATA_W-1:0] r1_in;
  logic [DATA_W-1:0] r2_in;
  logic [REG_W-1:0]  rd_in;
  logic [REG_W-1:0]  rs_in;
  logic [REG_W-1:0]  rt_in;

  logic              valid_out;
  logic [ALU_W-1:0]  alu_sig_out;
  logic              wb_out;
  logic [DATA_W-1:0] r1_out;
  logic [DATA_W-1:0] r2_out;
  logic [REG_W-1:0]  rd_out;
  logic [REG_W-1:0]  rs_out;
  logic [REG_W-1:0]  rt_out;
`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  modport master (
    output stall, flush, valid_in, alu_sig_in, wb_in,
           r1_in, r2_in, rd_in, rs_in, rt_in,
    input  valid_out, alu_sig_out, wb_out,
           r1_out, r2_out, rd_out, rs_out, rt_out
`ifdef IDEX_PERF_CNT_EN
    , input stall_cnt, bubble_cnt
`endif
  );

  modport slave (
    input  stall, flush, valid_in, alu_sig_in, wb_in,
           r1_in, r2_in, rd_in, rs_in, rt_in,
    output valid_out, alu_sig_out, wb_out,
           r1_out, r2_out, rd_out, rs_out, rt_out
`ifdef IDEX_PERF_CNT_EN
    , output stall_cnt, bubble_cnt
`endif
  );

endinterface

// File: rtl/idex_perf_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module idex_perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with valid bit, stall (hold) and flush (bubble).
// Define IDEX_PERF_CNT_EN to add saturating stall/bubble cycle counters.
module idex_stage_reg
  import idex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int ALU_W  = ALU_W_DEF
`ifdef IDEX_PERF_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  idex_stage_reg_if.slave bus
);

  // Same layout as idex_bundle_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ALU_W-1:0]  alu_sig;
    logic              wb;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
  } stage_t;

  stage_t bundle_q, bundle_d;
  logic   valid_q, valid_d;

  always_comb begin
    bundle_d = bundle_q;
    valid_d  = valid_q;
    if (bus.flush) begin
      // Zero indices so the forwarding unit never matches a bubble.
      valid_d          = 1'b0;
      bundle_d.alu_sig = ALU_W'(ALU_NOP);
      bundle_d.wb      = 1'b0;
      bundle_d.r1      = '0;
      bundle_d.r2      = '0;
      bundle_d.rd      = REG_W'(REG_ZERO);
      bundle_d.rs      = REG_W'(REG_ZERO);
      bundle_d.rt      = REG_W'(REG_ZERO);
    end else if (!bus.stall) begin
      valid_d          = bus.valid_in;
      bundle_d.alu_sig = bus.valid_in ? bus.alu_sig_in : ALU_W'(ALU_NOP);
      bundle_d.wb      = bus.wb_in & bus.valid_in;
      bundle_d.r1      = bus.r1_in;
      bundle_d.r2      = bus.r2_in;
      bundle_d.rd      = bus.rd_in;
      bundle_d.rs      = bus.rs_in;
      bundle_d.rt      = bus.rt_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      bundle_q <= bundle_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.valid_out   = valid_q;
  assign bus.alu_sig_out = bundle_q.alu_sig;
  assign bus.wb_out      = bundle_q.wb;
  assign bus.r1_out      = bundle_q.r1;
  assign bus.r2_out      = bundle_q.r2;
  assign bus.rd_out      = bundle_q.rd;
  assign bus.rs_out      = bundle_q.rs;
  assign bus.rt_out      = bundle_q.rt;

`ifdef IDEX_PERF_CNT_EN
  // A load of an invalid decode slot also counts as a bubble.
  logic stall_inc, bubble_inc;
  assign stall_inc  = bus.stall & ~bus.flush;
  assign bubble_inc = bus.flush | (~bus.stall & ~bus.valid_in);

  idex_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_inc),
    .cnt_o (bus.stall_cnt)
  );

  idex_perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (bubble_inc),
    .cnt_o (bus.bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_idex_stage_reg.sv
// Self-checking bench for idex_stage_reg: directed scenarios plus random traffic
// against a rule-level model. Counter checks appear when IDEX_PERF_CNT_EN is defined.
module tb_idex_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  idex_stage_reg_if bus ();

  idex_stage_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef IDEX_PERF_CNT_EN
  // Narrow-counter copy sharing the same stimulus, used for saturation.
  idex_stage_reg_if #(.CNT_W(4)) bus4 ();

  idex_stage_reg #(.CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  assign bus4.stall      = bus.stall;
  assign bus4.flush      = bus.flush;
  assign bus4.valid_in   = bus.valid_in;
  assign bus4.alu_sig_in = bus.alu_sig_in;
  assign bus4.wb_in      = bus.wb_in;
  assign bus4.r1_in      = bus.r1_in;
  assign bus4.r2_in      = bus.r2_in;
  assign bus4.rd_in      = bus.rd_in;
  assign bus4.rs_in      = bus.rs_in;
  assign bus4.rt_in      = bus.rt_in;
`endif

  int nChecks = 0;
  int nFail   = 0;

  // Reference model state: what execute should hold after each edge.
  logic       eValid;
  logic [2:0] eAlu;
  logic       eWb;
  logic [7:0] eR1, eR2;
  logic [4:0] eRd, eRs, eRt;
  int         eStallCnt, eBubbleCnt;

  function automatic logic [35:0] dutVec();
    return {bus.valid_out, bus.alu_sig_out, bus.wb_out, bus.r1_out, bus.r2_out,
            bus.rd_out, bus.rs_out, bus.rt_out};
  endfunction

  function automatic logic [35:0] expVec();
    return {eValid, eAlu, eWb, eR1, eR2, eRd, eRs, eRt};
  endfunction

  // Edge rules in priority order: reset, flush, stall, load.
  task automatic modelEdge();
    if (rst) begin
      {eValid, eAlu, eWb, eR1, eR2, eRd, eRs, eRt} = '0;
      eStallCnt  = 0;
      eBubbleCnt = 0;
    end else if (bus.flush) begin
      {eValid, eAlu, eWb, eR1, eR2, eRd, eRs, eRt} = '0;
      if (eBubbleCnt < 65535) eBubbleCnt++;
    end else if (bus.stall) begin
      if (eStallCnt < 65535) eStallCnt++;
    end else begin
      eValid = bus.valid_in;
      eWb    = bus.wb_in && bus.valid_in;
      eAlu   = bus.valid_in ? bus.alu_sig_in : 3'd0;
      eR1 = bus.r1_in; eR2 = bus.r2_in;
      eRd = bus.rd_in; eRs = bus.rs_in; eRt = bus.rt_in;
      if (!bus.valid_in && eBubbleCnt < 65535) eBubbleCnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] alu, input logic wb,
                               input logic [7:0] r1, input logic [7:0] r2,
                               input logic [4:0] rd, input logic [4:0] rs,
                               input logic [4:0] rt);
    bus.valid_in = v; bus.alu_sig_in = alu; bus.wb_in = wb;
    bus.r1_in = r1; bus.r2_in = r2;
    bus.rd_in = rd; bus.rs_in = rs; bus.rt_in = rt;
  endtask

  task automatic doReset();
    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 3'b111, 1'b1, 8'hFF, 8'hFF, 5'd31, 5'd31, 5'd31);
    doReset();
    nChecks++;
    if (dutVec() !== 36'd0) begin
      nFail++; $display("[TB] FAIL reset_outputs got %h want 0", dutVec());
    end
  endtask

  task automatic test_load();
    doReset();
    applyStimulus(1'b1, 3'b101, 1'b1, 8'hA5, 8'h3C, 5'd7, 5'd2, 5'd3);
    tick();
    nChecks++;
    if (dutVec() !== {1'b1, 3'b101, 1'b1, 8'hA5, 8'h3C, 5'd7, 5'd2, 5'd3}) begin
      nFail++; $display("[TB] FAIL load_outputs got %h", dutVec());
    end
  endtask

  task automatic test_stall();
    doReset();
    applyStimulus(1'b1, 3'b101, 1'b1, 8'hA5, 8'h3C, 5'd7, 5'd2, 5'd3);
    tick();
    applyStimulus(1'b1, 3'b101, 1'b1, 8'hFF, 8'h3C, 5'd9, 5'd2, 5'd3);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++;
      if (bus.r1_out !== 8'hA5 || bus.rd_out !== 5'd7 || bus.valid_out !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL stall_hold cycle %0d got r1=%h rd=%0d v=%b want A5/7/1",
                 i, bus.r1_out, bus.rd_out, bus.valid_out);
      end
    end
    bus.stall = 1'b0;
    tick();
    nChecks++;
    if (bus.r1_out !== 8'hFF || bus.rd_out !== 5'd9) begin
      nFail++;
      $display("[TB] FAIL stall_release got r1=%h rd=%0d want FF/9", bus.r1_out, bus.rd_out);
    end
`ifdef IDEX_PERF_CNT_EN
    nChecks++;
    if (bus.stall_cnt !== 16'd3) begin
      nFail++; $display("[TB] FAIL stall_cnt got %0d want 3", bus.stall_cnt);
    end
`endif
  endtask

  task automatic test_flush_over_stall();
    doReset();
    applyStimulus(1'b1, 3'b101, 1'b1, 8'hA5, 8'h3C, 5'd7, 5'd2, 5'd3);
    tick();
    bus.stall = 1'b1; bus.flush = 1'b1;
    tick();
    bus.stall = 1'b0; bus.flush = 1'b0;
    nChecks++;
    if (dutVec() !== 36'd0) begin
      nFail++; $display("[TB] FAIL flush_bubble got %h want 0", dutVec());
    end
`ifdef IDEX_PERF_CNT_EN
    nChecks++;
    if (bus.bubble_cnt !== 16'd1 || bus.stall_cnt !== 16'd0) begin
      nFail++;
      $display("[TB] FAIL flush_counters got bubble=%0d stall=%0d want 1/0",
               bus.bubble_cnt, bus.stall_cnt);
    end
`endif
  endtask

  task automatic test_invalid_gating();
    doReset();
    applyStimulus(1'b0, 3'b110, 1'b1, 8'h12, 8'h34, 5'd4, 5'd5, 5'd6);
    tick();
    nChecks++;
    if (dutVec() !== {1'b0, 3'b000, 1'b0, 8'h12, 8'h34, 5'd4, 5'd5, 5'd6}) begin
      nFail++; $display("[TB] FAIL invalid_gating got %h", dutVec());
    end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    applyStimulus(1'b1, 3'b011, 1'b1, 8'h5A, 8'hC3, 5'd11, 5'd12, 5'd13);
    tick();
    bus.stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.stall = 1'b0;
    nChecks++;
    if (dutVec() !== 36'd0) begin
      nFail++; $display("[TB] FAIL reset_mid_stall got %h want 0", dutVec());
    end
`ifdef IDEX_PERF_CNT_EN
    nChecks++;
    if (bus.stall_cnt !== 16'd0 || bus.bubble_cnt !== 16'd0) begin
      nFail++;
      $display("[TB] FAIL reset_counters got stall=%0d bubble=%0d want 0/0",
               bus.stall_cnt, bus.bubble_cnt);
    end
`endif
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 300; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      tick();
      nChecks++;
      if (dutVec() !== expVec()) begin
        nFail++;
        $display("[TB] FAIL random_outputs cycle %0d got %h want %h", i, dutVec(), expVec());
      end
`ifdef IDEX_PERF_CNT_EN
      nChecks++;
      if (bus.stall_cnt !== 16'(eStallCnt) || bus.bubble_cnt !== 16'(eBubbleCnt)) begin
        nFail++;
        $display("[TB] FAIL random_counters cycle %0d got %0d/%0d want %0d/%0d",
                 i, bus.stall_cnt, bus.bubble_cnt, eStallCnt, eBubbleCnt);
      end
`endif
    end
    rst = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

`ifdef IDEX_PERF_CNT_EN
  task automatic test_saturation();
    doReset();
    bus.stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      nChecks++;
      if (bus4.stall_cnt !== ((i + 1 < 15) ? 4'(i + 1) : 4'hF)) begin
        nFail++;
        $display("[TB] FAIL saturation cycle %0d got %h want %h", i, bus4.stall_cnt,
                 ((i + 1 < 15) ? 4'(i + 1) : 4'hF));
      end
    end
    bus.stall = 1'b0;
    nChecks++;
    if (bus.stall_cnt !== 16'd20) begin
      nFail++; $display("[TB] FAIL wide_stall_cnt got %0d want 20", bus.stall_cnt);
    end
  endtask
`endif

  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    applyStimulus(1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_load();
    test_stall();
    test_flush_over_stall();
    test_invalid_gating();
    test_reset_mid_stall();
    test_random();
`ifdef IDEX_PERF_CNT_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
